// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse types, element encoding and length-width helper
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WAIT    = 2'd2
    } asm_state_e;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    // Bits needed to hold an element count of 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/morse_gap_timer.sv
// rtl/morse_gap_timer.sv - idle-cycle counter that pulses expire on the last gap cycle
module morse_gap_timer #(
    parameter int GAP_CYCLES = 8
) (
    input  logic CLK,
    input  logic ASYNCRESET,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(GAP_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle means a new element arrived, which beats completion.
    assign expire = enable && !clear && (cnt_q == TW'(GAP_CYCLES - 1));

endmodule

// File: rtl/morse_symbol_assembler.sv
// rtl/morse_symbol_assembler.sv - packs dot/dash pulses into symbols; optional err via MORSE_ASM_ERR_EN
module morse_symbol_assembler
    import morse_pkg::*;
#(
    parameter int MAX_LEN    = 5,
    parameter int GAP_CYCLES = 8
) (
    input  logic                             CLK,
    input  logic                             ASYNCRESET,
    input  logic                             dot,
    input  logic                             dash,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [len_width(MAX_LEN)-1:0]    out_len,
    output logic [MAX_LEN-1:0]               out_pattern
`ifdef MORSE_ASM_ERR_EN
    ,
    output logic                             err
`endif
);

    localparam int LW = len_width(MAX_LEN);

    asm_state_e        state_q, state_d;
    logic [LW-1:0]     count_q, count_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic              out_valid_q, out_valid_d;
    logic [LW-1:0]     out_len_q, out_len_d;
    logic [MAX_LEN-1:0] out_pattern_q, out_pattern_d;

    logic ev, elem, out_free, load, timer_clear, timer_en, expire;

    assign ev          = dot | dash;
    assign elem        = dash ? ELEM_DASH : ELEM_DOT;
    assign out_free    = !out_valid_q || out_ready;
    assign timer_clear = ev && (state_q != ST_WAIT);
    assign timer_en    = (state_q == ST_COLLECT);

    morse_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .CLK       (CLK),
        .ASYNCRESET(ASYNCRESET),
        .clear     (timer_clear),
        .enable    (timer_en),
        .expire    (expire)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pattern_d = pattern_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    pattern_d    = '0;
                    pattern_d[0] = elem;
                    count_d      = LW'(1);
                    state_d      = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (ev) begin
                    if (count_q != LW'(MAX_LEN)) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (count_q == LW'(i)) pattern_d[i] = elem;
                        end
                        count_d = count_q + LW'(1);
                    end
                end else if (expire) begin
                    if (out_free) begin
                        load      = 1'b1;
                        count_d   = '0;
                        pattern_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (out_free) begin
                    load      = 1'b1;
                    count_d   = '0;
                    pattern_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                count_d   = '0;
                pattern_d = '0;
            end
        endcase
    end

    // A reload in the handshake cycle takes priority, so back-to-back symbols have no bubble.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_len_d     = out_len_q;
        out_pattern_d = out_pattern_q;
        if (load) begin
            out_valid_d   = 1'b1;
            out_len_d     = count_q;
            out_pattern_d = pattern_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d   = 1'b0;
            out_len_d     = '0;
            out_pattern_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            pattern_q     <= '0;
            out_valid_q   <= 1'b0;
            out_len_q     <= '0;
            out_pattern_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pattern_q     <= pattern_d;
            out_valid_q   <= out_valid_d;
            out_len_q     <= out_len_d;
            out_pattern_q <= out_pattern_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_len     = out_len_q;
    assign out_pattern = out_pattern_q;

`ifdef MORSE_ASM_ERR_EN
    logic dropped, err_q;

    assign dropped = ev && (((state_q == ST_COLLECT) && (count_q == LW'(MAX_LEN)))
                            || (state_q == ST_WAIT));

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | dropped;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// tb/tb_morse_symbol_assembler.sv - directed self-checking bench for morse_symbol_assembler
module tb_morse_symbol_assembler;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b0;
    logic       dot = 1'b0;
    logic       dash = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_len;
    logic [4:0] out_pattern;
`ifdef MORSE_ASM_ERR_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    morse_symbol_assembler #(
        .MAX_LEN   (5),
        .GAP_CYCLES(8)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .dot        (dot),
        .dash       (dash),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_len    (out_len),
        .out_pattern(out_pattern)
`ifdef MORSE_ASM_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        @(negedge CLK);
        ASYNCRESET = 1'b1;
        dot = 1'b0;
        dash = 1'b0;
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        step();
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (out_len !== 3'd0) begin n_bad++; $display("FAIL reset_len got=%0d exp=0", out_len); end
        n_cmp++;
        if (out_pattern !== 5'b00000) begin n_bad++; $display("FAIL reset_pattern got=%b exp=00000", out_pattern); end
`ifdef MORSE_ASM_ERR_EN
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    endtask

    task automatic test_basic_symbol;
        do_reset();
        out_ready = 1'b1;
        dot = 1'b1; step(); dot = 1'b0;
        step();
        dash = 1'b1; step(); dash = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid t+%0d got=%b exp=0", k, out_valid); end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_cmp++;
        if (out_len !== 3'd2) begin n_bad++; $display("FAIL basic_len got=%0d exp=2", out_len); end
        n_cmp++;
        if (out_pattern !== 5'b00010) begin n_bad++; $display("FAIL basic_pattern got=%b exp=00010", out_pattern); end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_one_cycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dash = 1'b1; step(); dash = 1'b0;
            if (i < 5) step();
        end
        repeat (8) step();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
        n_cmp++;
        if (out_len !== 3'd5) begin n_bad++; $display("FAIL ovf_len got=%0d exp=5", out_len); end
        n_cmp++;
        if (out_pattern !== 5'b11111) begin n_bad++; $display("FAIL ovf_pattern got=%b exp=11111", out_pattern); end
`ifdef MORSE_ASM_ERR_EN
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got=%b exp=1", err); end
`endif
    endtask

    task automatic test_back_to_back;
        do_reset();
        out_ready = 1'b0;
        dot = 1'b1; step(); dot = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd1 || out_pattern !== 5'b00000) begin
            n_bad++; $display("FAIL b2b_first got=%b/%0d/%b exp=1/1/00000", out_valid, out_len, out_pattern);
        end
        dash = 1'b1; step(); dash = 1'b0;
        dot = 1'b1; step(); dot = 1'b0;
        repeat (10) step();
        dot = 1'b1; step(); dot = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd1 || out_pattern !== 5'b00000) begin
            n_bad++; $display("FAIL b2b_held got=%b/%0d/%b exp=1/1/00000", out_valid, out_len, out_pattern);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd2 || out_pattern !== 5'b00001) begin
            n_bad++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/2/00001", out_valid, out_len, out_pattern);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
        repeat (10) step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_wait_drop got=%b exp=0", out_valid); end
`ifdef MORSE_ASM_ERR_EN
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL b2b_err got=%b exp=1", err); end
`endif
    endtask

    task automatic test_dot_dash_same;
        do_reset();
        out_ready = 1'b1;
        dot = 1'b1; dash = 1'b1; step(); dot = 1'b0; dash = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd1 || out_pattern !== 5'b00001) begin
            n_bad++; $display("FAIL both_sym got=%b/%0d/%b exp=1/1/00001", out_valid, out_len, out_pattern);
        end
    endtask

    task automatic test_completion_event;
        do_reset();
        out_ready = 1'b1;
        dot = 1'b1; step(); dot = 1'b0;
        repeat (7) step();
        dash = 1'b1; step(); dash = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL late_no_output k=%0d got=%b exp=0", k, out_valid); end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd2 || out_pattern !== 5'b00010) begin
            n_bad++; $display("FAIL late_sym got=%b/%0d/%b exp=1/2/00010", out_valid, out_len, out_pattern);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        out_ready = 1'b1;
        dot = 1'b1; step(); dot = 1'b0;
        dash = 1'b1; step(); dash = 1'b0;
        #2 ASYNCRESET = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_len !== 3'd0 || out_pattern !== 5'b00000) begin
            n_bad++; $display("FAIL rst_mid got=%b/%0d/%b exp=0/0/00000", out_valid, out_len, out_pattern);
        end
        #2 ASYNCRESET = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_partial_discard k=%0d got=%b exp=0", k, out_valid); end
            step();
        end
        out_ready = 1'b0;
        dash = 1'b1; step(); dash = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_prefill got=%b exp=1", out_valid); end
        #2 ASYNCRESET = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_len !== 3'd0 || out_pattern !== 5'b00000) begin
            n_bad++; $display("FAIL rst_valid got=%b/%0d/%b exp=0/0/00000", out_valid, out_len, out_pattern);
        end
        #2 ASYNCRESET = 1'b0;
        out_ready = 1'b1;
        dot = 1'b1; step(); dot = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_len !== 3'd1 || out_pattern !== 5'b00000) begin
            n_bad++; $display("FAIL rst_fresh got=%b/%0d/%b exp=1/1/00000", out_valid, out_len, out_pattern);
        end
    endtask

    initial begin
        test_reset();
        test_basic_symbol();
        test_overflow();
        test_back_to_back();
        test_dot_dash_same();
        test_completion_event();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
